d_pipe_reg: RTL
===============

Name: d_pipe_reg

Overview:
- Parametrised successor to the team's single-bit D flip-flop.
- WIDTH-bit, DEPTH-stage registered delay line that carries a valid flag alongside each stage.
- Adds global clock enable (stall), synchronous flush, a parametrised reset value, registered true/complement outputs and an occupancy count.
- Used to balance pipeline latency between datapath branches and to retime buses crossing long routes.

Parameters:
- WIDTH, 8: data width in bits (>=1).
- DEPTH, 3: number of register stages, i.e. latency in enabled cycles (>=1).
- RESET_VAL, 0: data value loaded into every stage on reset and on flush (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; 0 = whole pipe holds.
- flush  input  1  synchronous clear of all stages.
- din  input  WIDTH  data into stage 0.
- din_valid  input  1  qualifies din.
- q  output  WIDTH  data of last stage (registered).
- q_bar  output  WIDTH  bitwise complement of q (registered).
- q_valid  output  1  valid flag of last stage.
- occupancy  output  CW  count of valid stages, 0..DEPTH; CW = $clog2(DEPTH+1).

Behaviour:
- One clock: clk. Reset is asynchronous, active-low: rst_n.
- Reset (rst_n=0, immediate, no clock needed):
  - all stage data = RESET_VAL; all valid = 0.
  - q = RESET_VAL, q_bar = ~RESET_VAL, q_valid = 0, occupancy = 0.
- Release of rst_n is synchronised externally; the block samples normally from the first rising edge with rst_n=1.
- Priority per rising edge: flush > en > hold.
- Flush (flush=1, any en):
  - all stage data = RESET_VAL, all valid = 0, occupancy = 0.
  - the din/din_valid presented that cycle are discarded.
- Advance (flush=0, en=1):
  - stage0 <= {din, din_valid}; stage[i] <= stage[i-1] for i=1..DEPTH-1.
  - data shifts regardless of valid, so invalid slots carry their stale data forward.
- Hold (flush=0, en=0): all stages, q, q_bar, q_valid and occupancy unchanged.
- Outputs:
  - q and q_valid are the contents of stage DEPTH-1.
  - q_bar is a separately registered copy loaded with ~(next q) on the same edge, so q_bar == ~q on every cycle, including reset.
- Latency: a sample accepted on enabled edge N appears on q after enabled edge N+DEPTH-1, i.e. DEPTH enabled edges after being driven. Non-enabled cycles stretch the latency and drop nothing.
- Occupancy:
  - registered; on an advance edge, next = occupancy + din_valid − q_valid (the value leaving stage DEPTH-1).
  - never exceeds DEPTH and never goes below 0 (guaranteed by construction; an assertion checks it).
  - equals popcount of the stage valid flags after every edge.
- DEPTH=1: a single register with the same enable, flush and complement semantics.
- Reset asserted mid-stream: all in-flight samples are lost and no partial state survives.

Decomposition:
- Shared package d_pipe_pkg:
  - function clog2_depth(DEPTH) returning CW.
  - a packed struct type for one stage {data, valid}, parameterised via a typedef macro or per-instance localparam.
- Sub-module d_pipe_stage: one WIDTH+1-bit register with rst_n, en, flush and RESET_VAL.
- Top level:
  - generates DEPTH instances of d_pipe_stage chained together.
  - adds the q_bar register, occupancy counter and assertions.

Test Plan (WIDTH=8, DEPTH=3, RESET_VAL=8'h00):
- Reset: rst_n=0 asynchronously mid-cycle -> q=8'h00, q_bar=8'hFF, q_valid=0, occupancy=0 before the next edge.
- Streaming: en=1, drive valid 8'hA5, 8'h3C, 8'h0F on consecutive edges.
  - q=8'hA5, q_valid=1, q_bar=8'h5A after the 3rd edge.
  - then 8'h3C and 8'h0F on the following edges.
  - occupancy sequence 1,2,3,3.
- Stall: after loading 8'h11 and 8'h22, hold en=0 for 5 cycles -> q, q_valid and occupancy=2 frozen. Resume en=1 -> 8'h11 exits on the 1st enabled edge after resuming.
- Bubbles: pattern valid,invalid,valid (8'h01, x, 8'h03) -> q_valid sequence 1,0,1 at the output; occupancy peaks at 2.
- Flush priority: pipe full (occupancy=3) with flush=1, en=1, din=8'hEE valid -> next cycle q=8'h00, q_valid=0, occupancy=0, and 8'hEE never appears.
- Parameter sweep: DEPTH=1 and RESET_VAL=8'h5A.
  - reset -> q=8'h5A, q_bar=8'hA5.
  - single-cycle latency for valid 8'hC3.
  - occupancy toggles between 0 and 1.

Source files
------------

// File: rtl/d_pipe_pkg.sv
// Shared types and helpers for the d_pipe_reg delay line.
// The stage record {data, valid} depends on WIDTH, so it is provided as a
// typedef macro that each module expands with its own WIDTH.
`ifndef D_PIPE_STAGE_T
`define D_PIPE_STAGE_T(W) struct packed { logic [(W)-1:0] data; logic valid; }
`endif

package d_pipe_pkg;

  // Valid flag value held by a stage after reset or flush.
  localparam logic STAGE_RST_VALID = 1'b0;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int clog2_depth(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One {data, valid} register of the delay line.
// Latency: 1 enabled edge. Backpressure: en=0 holds the stage, flush clears it.
// Reset and flush both load RESET_VAL with the valid flag cleared.
module d_pipe_stage
  import d_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  typedef `D_PIPE_STAGE_T(WIDTH) stage_t;

  stage_t r_stage;

  // Stage register: flush beats enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage.data  <= RESET_VAL;
      r_stage.valid <= STAGE_RST_VALID;
    end else if (flush) begin
      r_stage.data  <= RESET_VAL;
      r_stage.valid <= STAGE_RST_VALID;
    end else if (en) begin
      r_stage.data  <= i_data;
      r_stage.valid <= i_valid;
    end
  end

  assign o_data  = r_stage.data;
  assign o_valid = r_stage.valid;

endmodule

// File: rtl/d_pipe_reg.sv
// WIDTH-bit, DEPTH-stage registered delay line with per-stage valid flags.
// Latency: DEPTH enabled edges from din to q. Backpressure: en=0 stalls the
// whole pipe without loss; flush clears every stage and drops that cycle's din.
module d_pipe_reg
  import d_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              din,
  input  logic                          din_valid,
  output logic [WIDTH-1:0]              q,
  output logic [WIDTH-1:0]              q_bar,
  output logic                          q_valid,
  output logic [clog2_depth(DEPTH)-1:0] occupancy
);

  localparam int CW = clog2_depth(DEPTH);

  typedef `D_PIPE_STAGE_T(WIDTH) stage_t;

  stage_t           w_stage_in  [DEPTH];
  stage_t           w_stage_out [DEPTH];
  logic [DEPTH-1:0] w_valid_vec;
  logic [WIDTH-1:0] r_q_bar;
  logic [CW-1:0]    r_occ;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_stage_in[gi] = {din, din_valid};
      end else begin : g_link
        assign w_stage_in[gi] = w_stage_out[gi-1];
      end

      d_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .flush   (flush),
        .i_data  (w_stage_in[gi].data),
        .i_valid (w_stage_in[gi].valid),
        .o_data  (w_stage_out[gi].data),
        .o_valid (w_stage_out[gi].valid)
      );

      assign w_valid_vec[gi] = w_stage_out[gi].valid;
    end
  endgenerate

  // Complement register loads ~(next q) on the same edge as the last stage,
  // so q_bar never lags q; the next q is whatever feeds the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_bar <= ~RESET_VAL;
    end else if (flush) begin
      r_q_bar <= ~RESET_VAL;
    end else if (en) begin
      r_q_bar <= ~w_stage_in[DEPTH-1].data;
    end
  end

  // Occupancy: one in when din_valid, one out when the last stage was valid.
  // The true result is always 0..DEPTH, so CW-bit wraparound arithmetic is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (en) begin
      r_occ <= r_occ + CW'(din_valid) - CW'(w_stage_out[DEPTH-1].valid);
    end
  end

  assign q         = w_stage_out[DEPTH-1].data;
  assign q_valid   = w_stage_out[DEPTH-1].valid;
  assign q_bar     = r_q_bar;
  assign occupancy = r_occ;

  a_occ_range : assert property (@(posedge clk) disable iff (!rst_n)
    int'(r_occ) <= int'(DEPTH));

  a_occ_popcount : assert property (@(posedge clk) disable iff (!rst_n)
    int'(r_occ) == $countones(w_valid_vec));

  a_q_bar : assert property (@(posedge clk) disable iff (!rst_n)
    r_q_bar == ~q);

endmodule
